lzs_out_pack: RTL

Output packer between the LZS encoder's 16-bit compressed-word stream and the 64-bit destination bus. Gathers 16-bit words into 64-bit beats, buffers them in a small FIFO, and drives the destination write strobe under `fo_full` backpressure. On end of stream it flushes a zero-padded last beat and pulses the end-of-job strobe.

---
 rtl/lzs_out_pack_if.sv | 26 ++
 rtl/lzs_out_pack.sv | 137 +++++++++++++
 2 files changed

// File: rtl/lzs_out_pack_if.sv
// Bus bundle for the LZS output packer: upstream word stream in,
// 64-bit destination beats out. master = packer side, slave = environment side.
interface lzs_out_pack_if #(
    parameter int CNT_W = 16
) ();
    logic [15:0]      di;
    logic             die;
    logic             dlast;
    logic             dfull;
    logic             fo_full;
    logic [63:0]      m_dst;
    logic             m_dst_putn;
    logic             m_dst_last;
    logic             m_endn;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        input  di, die, dlast, fo_full,
        output dfull, m_dst, m_dst_putn, m_dst_last, m_endn, beat_cnt
    );

    modport slave (
        output di, die, dlast, fo_full,
        input  dfull, m_dst, m_dst_putn, m_dst_last, m_endn, beat_cnt
    );
endinterface

// File: rtl/lzs_out_pack.sv
// LZS output packer: gathers 16-bit words into 64-bit beats, queues them in a
// small FIFO and drains to the destination under fo_full backpressure.
module lzs_out_pack #(
    parameter int FIFO_AW = 2,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    lzs_out_pack_if.master bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] HIGH_C  = (FIFO_AW + 1)'(DEPTH - 1);

    logic [63:0]        acc_r;
    logic [1:0]         lane_r;
    logic               full_r;
    logic [64:0]        mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               dfull_r;
    logic [63:0]        m_dst_r;
    logic               putn_r;
    logic               last_r;
    logic               endn_r;
    logic [CNT_W-1:0]   beat_cnt_r;

    logic               push_s;
    logic               pop_s;
    logic               push_en_s;
    logic [64:0]        push_entry_s;
    logic [FIFO_AW:0]   count_next_s;

    // Push/pop decisions and next FIFO occupancy
    always_comb begin
        push_s       = (bus.die && full_r) || bus.dlast;
        pop_s        = (count_r != {(FIFO_AW + 1){1'b0}}) && !bus.fo_full;
        // a full FIFO only takes a push if the head leaves in the same edge
        push_en_s    = push_s && ((count_r != DEPTH_C) || pop_s);
        push_entry_s = {bus.dlast, acc_r};
        case ({push_en_s, pop_s})
            2'b10:   count_next_s = count_r + {{FIFO_AW{1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{FIFO_AW{1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // Word accumulator: lane 0 lands in [63:48]; a full word set is held until the next trigger
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r  <= 64'h0;
            lane_r <= 2'd0;
            full_r <= 1'b0;
        end else if (bus.die) begin
            if (full_r) begin
                acc_r  <= {bus.di, 48'h0};
                lane_r <= 2'd1;
                full_r <= 1'b0;
            end else begin
                acc_r[{~lane_r, 4'd0} +: 16] <= bus.di;
                lane_r <= lane_r + 2'd1;
                full_r <= (lane_r == 2'd3);
            end
        end else if (bus.dlast) begin
            acc_r  <= 64'h0;
            lane_r <= 2'd0;
            full_r <= 1'b0;
        end else begin
            acc_r  <= acc_r;
            lane_r <= lane_r;
            full_r <= full_r;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so the array needs no reset
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and the registered upstream stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW + 1){1'b0}};
            dfull_r  <= 1'b0;
        end else begin
            wr_ptr_r <= push_en_s ? wr_ptr_r + {{(FIFO_AW - 1){1'b0}}, 1'b1} : wr_ptr_r;
            rd_ptr_r <= pop_s ? rd_ptr_r + {{(FIFO_AW - 1){1'b0}}, 1'b1} : rd_ptr_r;
            count_r  <= count_next_s;
            // one slot stays free for a held accumulator flushed by dlast
            dfull_r  <= (count_next_s >= HIGH_C);
        end
    end

    // Destination side: beat strobe, end-of-job pulse and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dst_r    <= 64'h0;
            last_r     <= 1'b0;
            putn_r     <= 1'b1;
            endn_r     <= 1'b1;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (pop_s) begin
                m_dst_r <= mem_r[rd_ptr_r][63:0];
                last_r  <= mem_r[rd_ptr_r][64];
                putn_r  <= 1'b0;
            end else begin
                m_dst_r <= m_dst_r;
                last_r  <= last_r;
                putn_r  <= 1'b1;
            end
            endn_r <= !(!putn_r && last_r);
            // the end-of-job cycle restarts counting; a next-stream beat there counts as one
            if (!endn_r) begin
                beat_cnt_r <= putn_r ? {CNT_W{1'b0}} : {{(CNT_W - 1){1'b0}}, 1'b1};
            end else if (!putn_r) begin
                beat_cnt_r <= beat_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    assign bus.dfull      = dfull_r;
    assign bus.m_dst      = m_dst_r;
    assign bus.m_dst_putn = putn_r;
    assign bus.m_dst_last = last_r;
    assign bus.m_endn     = endn_r;
    assign bus.beat_cnt   = beat_cnt_r;
endmodule
